// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO burst writer: FSM states and the
// LFSR constants (x^8+x^6+x^5+x^4+1) used by the pattern generator.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h01;

endpackage

// File: rtl/fifo_pattern_gen.sv
// Write-data pattern source: loads a seed on burst start, then steps either
// an incrementing counter or an 8-bit Fibonacci LFSR on each accepted word.
module fifo_pattern_gen
  import fifo_pkg::*;
#(
  parameter int DATA_LINES = 8
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  mode,
  input  logic                  load,
  input  logic [DATA_LINES-1:0] seed,
  input  logic                  advance,
  output logic [DATA_LINES-1:0] data
);

  logic                  mode_q;
  logic                  fb;
  logic [DATA_LINES-1:0] nxt;
  logic [DATA_LINES-1:0] load_val;

  always_comb begin
    fb  = ^(data & DATA_LINES'(LFSR_TAPS));
    nxt = mode_q ? {data[DATA_LINES-2:0], fb} : data + DATA_LINES'(1);
    // an all-zero seed would lock the LFSR, so substitute the canonical seed
    load_val = (mode && (seed == '0)) ? DATA_LINES'(LFSR_SEED) : seed;
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      data   <= '0;
      mode_q <= 1'b0;
    end else if (load) begin
      data   <= load_val;
      mode_q <= mode;
    end else if (advance) begin
      data   <= nxt;
    end
  end

endmodule

// File: rtl/fifo_burst_writer.sv
// Burst writer: pushes burst_len pattern words into a FIFO, honouring full,
// half-full throttling and abort, then pulses done for one cycle.
module fifo_burst_writer
  import fifo_pkg::*;
#(
  parameter int DATA_LINES = 8,
  parameter int LEN_W      = 16
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  start,
  input  logic [LEN_W-1:0]      burst_len,
  input  logic                  mode,
  input  logic [DATA_LINES-1:0] seed,
  input  logic                  abort,
  input  logic                  throttle_en,
  input  logic                  wfull,
  input  logic                  half_full,
  output logic                  winc,
  output logic [DATA_LINES-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      words_written
);

  state_t           state, state_nx;
  logic [LEN_W-1:0] remaining;
  logic             load;

  assign load = (state == IDLE) && start;
  assign winc = (state == WRITE) && !wfull && !(throttle_en && half_full) && !abort;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  fifo_pattern_gen #(.DATA_LINES(DATA_LINES)) u_pat (
    .wclk    (wclk),
    .wrst    (wrst),
    .mode    (mode),
    .load    (load),
    .seed    (seed),
    .advance (winc),
    .data    (wdata)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (burst_len == '0) ? DONE : WRITE;
      WRITE: begin
        if (abort)                                 state_nx = IDLE;
        else if (winc && remaining == LEN_W'(1))   state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      state         <= IDLE;
      remaining     <= '0;
      words_written <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        remaining     <= burst_len;
        words_written <= '0;
      end else if (winc) begin
        remaining     <= remaining - LEN_W'(1);
        words_written <= words_written + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Scoreboard bench: each burst's expected word stream and completion count are
// queued up front; a negedge monitor checks every write strobe and done pulse.
module tb_fifo_burst_writer;

  logic        wclk = 1'b0;
  logic        wrst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] burst_len = '0;
  logic        mode = 1'b0;
  logic [7:0]  seed = '0;
  logic        abort = 1'b0;
  logic        throttle_en = 1'b0;
  logic        wfull = 1'b0;
  logic        half_full = 1'b0;
  logic        winc;
  logic [7:0]  wdata;
  logic        busy;
  logic        done;
  logic [15:0] words_written;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_words[$];
  int         exp_done[$];

  logic       prev_stall = 1'b0;
  logic       prev_winc  = 1'b0;
  logic [7:0] prev_wdata = '0;

  always #5 wclk = ~wclk;

  fifo_burst_writer #(.DATA_LINES(8), .LEN_W(16)) dut (
    .wclk          (wclk),
    .wrst          (wrst),
    .start         (start),
    .burst_len     (burst_len),
    .mode          (mode),
    .seed          (seed),
    .abort         (abort),
    .throttle_en   (throttle_en),
    .wfull         (wfull),
    .half_full     (half_full),
    .winc          (winc),
    .wdata         (wdata),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // next pattern word from the data-pattern rules
  function automatic logic [7:0] next_word(input logic [7:0] d, input logic m);
    if (m) return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
    return 8'((int'(d) + 1) % 256);
  endfunction

  always @(negedge wclk) begin
    if (wrst) begin
      int e;
      if (winc) begin
        chk("winc_gating", longint'(wfull || (throttle_en && half_full) || abort), 0);
        if (exp_words.size() == 0) chk("winc_with_empty_queue", winc, 0);
        else chk("wdata", wdata, exp_words.pop_front());
      end
      if (done) begin
        if (exp_done.size() == 0) chk("spurious_done", done, 0);
        else begin
          e = exp_done.pop_front();
          chk("done_count", words_written, e);
          if (e > 0) chk("done_after_last", prev_winc, 1);
        end
      end
      if (prev_stall && busy && !done) chk("wdata_hold", wdata, prev_wdata);
      prev_stall = busy && !done && !winc && !abort;
      prev_winc  = winc;
      prev_wdata = wdata;
    end else begin
      prev_stall = 1'b0;
      prev_winc  = 1'b0;
    end
  end

  // kind: 0 clean, 1 random, 2 wfull x5 at word 2, 3 throttle x4 at word 2,
  // 4 half_full high with throttle disabled. ab>0 aborts after ab words.
  task automatic burst(input int len, input bit m, input logic [7:0] sd,
                       input int ab, input int kind, input int exp_stall);
    logic [7:0] d;
    int n, stalls, hold;
    bit fin;
    d = (m && sd == 8'h00) ? 8'h01 : sd;
    n = (ab > 0) ? ab : len;
    for (int i = 0; i < n; i++) begin
      exp_words.push_back(d);
      d = next_word(d, m);
    end
    if (ab == 0) exp_done.push_back(len);
    burst_len = 16'(len); mode = m; seed = sd; start = 1'b1;
    @(posedge wclk); #1;
    start = 1'b0; burst_len = 16'($urandom); seed = 8'($urandom); mode = 1'($urandom);
    if (len == 0) chk("zero_len_done", done, 1);
    stalls = 0; hold = 0; fin = 0;
    for (int c = 0; c < 400 && !fin; c++) begin
      if (!busy) fin = 1;
      else begin
        wfull = 0; half_full = 0; throttle_en = 0; abort = 0; start = 0;
        case (kind)
          1: begin
            wfull       = ($urandom % 4) == 0;
            throttle_en = 1'($urandom);
            half_full   = ($urandom % 3) == 0;
            start       = ($urandom % 5) == 0;
            abort       = done && (($urandom % 2) == 0);
          end
          2: if (words_written == 1 && hold < 5) begin wfull = 1; hold++; end
          3: begin
            throttle_en = 1;
            if (words_written == 1 && hold < 4) begin half_full = 1; hold++; end
          end
          4: half_full = 1;
          default: ;
        endcase
        if (ab > 0 && words_written == 16'(ab)) abort = 1;
        #3;
        if (busy && !done && !winc && !abort) stalls++;
        @(posedge wclk); #1;
      end
    end
    if (!fin) chk("burst_timeout", 0, 1);
    wfull = 0; half_full = 0; throttle_en = 0; abort = 0; start = 0;
    chk("final_count", words_written, (ab > 0) ? ab : len);
    chk("words_drained", exp_words.size(), 0);
    chk("done_drained", exp_done.size(), 0);
    if (exp_stall >= 0) chk("stall_cycles", stalls, exp_stall);
  endtask

  initial begin
    #1 wrst = 1'b0;
    #2;
    chk("rst_winc", winc, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_words", words_written, 0);
    @(posedge wclk); #1 wrst = 1'b1;

    burst(4, 0, 8'h10, 0, 0, 0);
    burst(3, 0, 8'h10, 0, 2, 5);
    burst(3, 1, 8'h00, 0, 0, 0);
    burst(2, 1, 8'h80, 0, 0, 0);
    burst(6, 0, 8'hFD, 0, 3, 4);
    burst(5, 1, 8'hA5, 0, 4, 0);
    burst(0, 0, 8'h33, 0, 0, 0);
    burst(10, 0, 8'h00, 2, 0, 0);

    for (int r = 0; r < 10; r++) begin
      int len, ab;
      len = $urandom_range(0, 12);
      ab  = (len > 2 && ($urandom % 3) == 0) ? $urandom_range(1, len - 1) : 0;
      burst(len, 1'($urandom), 8'($urandom), ab, 1, -1);
    end

    // asynchronous reset in the middle of a burst
    exp_words.delete();
    for (int i = 0; i < 10; i++) exp_words.push_back(8'(8'h40 + i));
    burst_len = 16'd10; mode = 0; seed = 8'h40; start = 1;
    @(posedge wclk); #1 start = 0;
    repeat (3) @(posedge wclk);
    #3 wrst = 1'b0;
    #1;
    chk("midrst_winc", winc, 0);
    chk("midrst_wdata", wdata, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_words", words_written, 0);
    exp_words.delete();
    exp_done.delete();
    repeat (2) @(posedge wclk);
    #1 wrst = 1'b1;
    burst(4, 0, 8'h10, 0, 0, 0);
    repeat (2) @(posedge wclk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_burst_writer.md
FIFO_BURST_WRITER -- requirements
Module: fifo_burst_writer

Interface
REQ-001 The block SHALL have parameter DATA_LINES, default 8, meaning write data width; only 8 is legal when LFSR mode is used.
REQ-002 The block SHALL have parameter LEN_W, default 16, meaning burst length and counter width.
REQ-003 The block SHALL have port wclk  input  1  write-domain clock.
REQ-004 The block SHALL have port wrst  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port start  input  1  single-cycle burst request.
REQ-006 The block SHALL have port burst_len  input  LEN_W  number of words, sampled with start.
REQ-007 The block SHALL have port mode  input  1  data pattern select: 0 increment, 1 LFSR; sampled with start.
REQ-008 The block SHALL have port seed  input  DATA_LINES  first data word, sampled with start.
REQ-009 The block SHALL have port abort  input  1  terminate the current burst.
REQ-010 The block SHALL have port throttle_en  input  1  stall writes while half_full is high.
REQ-011 The block SHALL have port wfull  input  1  FIFO full flag (wclk domain).
REQ-012 The block SHALL have port half_full  input  1  FIFO half-full flag (wclk domain).
REQ-013 The block SHALL have port winc  output  1  write strobe to FIFO.
REQ-014 The block SHALL have port wdata  output  DATA_LINES  write data to FIFO.
REQ-015 The block SHALL have port busy  output  1  burst in progress.
REQ-016 The block SHALL have port done  output  1  one-cycle pulse at burst completion.
REQ-017 The block SHALL have port words_written  output  LEN_W  count of accepted words in current or last burst.

Function
REQ-018 The FSM SHALL have states IDLE, WRITE and DONE.
REQ-019 In IDLE with start=1, the FSM SHALL load remaining=burst_len, wdata=seed (seed 0 in mode 1 replaced by 8'h01), latch mode, clear words_written, and go to WRITE, or to DONE if burst_len=0.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 winc SHALL be combinational: (state==WRITE) && !wfull && !(throttle_en && half_full) && !abort.
REQ-022 A word SHALL be accepted on each wclk edge where winc=1; there are no other acceptance conditions.
REQ-023 On acceptance: remaining SHALL decrement, words_written SHALL increment, and wdata SHALL advance to the next pattern value on the following cycle.
REQ-024 Mode 0: next = wdata+1, wrapping 8'hFF to 8'h00.
REQ-025 Mode 1: next = {wdata[6:0], wdata[7]^wdata[5]^wdata[4]^wdata[3]} (x^8+x^6+x^5+x^4+1, never 0).
REQ-026 Acceptance with remaining=1 SHALL move the FSM to DONE.
REQ-027 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start is ignored in DONE.
REQ-028 abort=1 in WRITE SHALL force winc=0 that cycle and return to IDLE next cycle, with no done pulse and words_written holding the accepted count.
REQ-029 abort in IDLE or DONE SHALL have no effect.
REQ-030 busy SHALL be 1 in WRITE and DONE, and 0 in IDLE.
REQ-031 wdata SHALL hold its value while stalled (wfull or throttle).
REQ-032 words_written SHALL hold after a burst until the next accepted start.
REQ-033 The block SHALL allow back-to-back bursts: start in the cycle after done is accepted.

Reset
REQ-034 On wrst=0 the block SHALL immediately enter IDLE with winc=0, wdata=0, busy=0, done=0, words_written=0 and remaining=0.
REQ-035 Reset mid-burst SHALL discard the burst, with no done pulse.
REQ-036 After wrst deasserts, the first start SHALL be honored on the next wclk edge.

Structure
REQ-037 Shared package fifo_pkg SHALL hold the state enum (IDLE, WRITE, DONE), the LFSR tap constant 8'hB8, and the LFSR non-zero seed 8'h01.
REQ-038 Pattern generation SHALL be one sub-module, fifo_pattern_gen (mode, load, seed, advance -> data).
REQ-039 The FSM, counters and winc logic SHALL stay in the top module.

Verification
REQ-040 Basic: start, burst_len=4, mode=0, seed=8'h10, wfull=0 -> winc high 4 cycles; wdata 10,11,12,13; done one cycle later; words_written=4.
REQ-041 Stall: burst_len=3, wfull=1 during the 2nd word for 5 cycles -> winc low for those 5 cycles, wdata holds 8'h11, 3 words total, done after the last.
REQ-042 LFSR: mode=1, seed=0, burst_len=3 -> wdata 01,02,04; with seed=8'h80, next word=8'h01.
REQ-043 Throttle: throttle_en=1, half_full=1 -> no writes; half_full falls -> writes resume; throttle_en=0 ignores half_full.
REQ-044 Abort/zero: burst_len=0 -> done the next cycle and no winc; abort after 2 of 10 words -> IDLE, no done, words_written=2.
REQ-045 Reset: wrst low mid-burst -> all outputs 0 asynchronously; a new start after release behaves as in REQ-040.
